// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_divider
// Function : Multi-cycle radix-2 restoring signed divider (truncate toward
//            zero). Optional `overflow` output under DIV_OVERFLOW_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
module seq_signed_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef DIV_OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
`ifdef DIV_OVERFLOW_FLAG_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    logic             ovf_pend_q, ovf_pend_d;
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    // rem < divisor always holds, so the shifted value fits in WIDTH bits and
    // trial[WIDTH] is a reliable borrow flag.
    assign rem_shift    = {rem_q, quo_q[WIDTH-1]};
    assign trial        = rem_shift - {1'b0, dvsr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            count_q     <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_OVERFLOW_FLAG_EN
            ovf_pend_q  <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            count_q     <= count_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_OVERFLOW_FLAG_EN
            ovf_pend_q  <= ovf_pend_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        count_d     = count_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_OVERFLOW_FLAG_EN
        ovf_pend_d  = ovf_pend_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    qneg_d      = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d      = dividend[WIDTH-1];
                    dvsr_d      = divisor_mag;
                    count_d     = CW'(WIDTH);
`ifdef DIV_OVERFLOW_FLAG_EN
                    ovf_d       = 1'b0;
                    ovf_pend_d  = (dividend == MIN_VAL) && (divisor == '1);
`endif
                    // Zero divisor parks |dividend| in rem so SIGN restores it.
                    if (divisor == '0) begin
                        zero_d  = 1'b1;
                        rem_d   = dividend_mag;
                        quo_d   = '0;
                        state_d = S_SIGN;
                    end else begin
                        zero_d  = 1'b0;
                        rem_d   = '0;
                        quo_d   = dividend_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d   = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = S_IDLE;
                remainder_d = rneg_q ? -rem_q : rem_q;
                if (zero_q) begin
                    quotient_d = '1;
                    dbz_d      = 1'b1;
                end else begin
                    quotient_d = qneg_q ? -quo_q : quo_q;
                end
`ifdef DIV_OVERFLOW_FLAG_EN
                ovf_d = ovf_pend_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
`ifdef DIV_OVERFLOW_FLAG_EN
    assign overflow    = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_signed_divider
// Function : Directed self-checking bench for seq_signed_divider (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_signed_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef DIV_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    int total = 0;
    int bad   = 0;

    seq_signed_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef DIV_OVERFLOW_FLAG_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Issues one request and waits for done; lat = edges after accept (-1 on
    // timeout), busy_hi = samples with busy high from accept until done.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int busy_hi);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busy_hi = busy ? 1 : 0;
        lat     = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_hi++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (quotient !== 4'h0) begin bad++; $display("FAIL reset_quot: got %h want 0", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL reset_rem: got %h want 0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bh;
        run_div(4'd7, 4'd2, lat, bh);
        total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        total++; if (bh !== 5) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 5", bh); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        total++; if (quotient !== 4'd3) begin bad++; $display("FAIL basic_quot: got %h want 3", quotient); end
        total++; if (remainder !== 4'd1) begin bad++; $display("FAIL basic_rem: got %h want 1", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        total++; if (quotient !== 4'd3) begin bad++; $display("FAIL basic_quot_held: got %h want 3", quotient); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a [3];
        logic [3:0] b [3];
        logic [3:0] eq [3];
        logic [3:0] er [3];
        int lat, bh;
        a[0] = 4'h9; b[0] = 4'h2; eq[0] = 4'hD; er[0] = 4'hF;  // -7 / 2
        a[1] = 4'h7; b[1] = 4'hD; eq[1] = 4'hE; er[1] = 4'h1;  //  7 / -3
        a[2] = 4'h8; b[2] = 4'hD; eq[2] = 4'h2; er[2] = 4'hE;  // -8 / -3
        for (int i = 0; i < 3; i++) begin
            run_div(a[i], b[i], lat, bh);
            total++; if (lat !== 5) begin bad++; $display("FAIL b2b%0d_latency: got %0d want 5", i, lat); end
            total++; if (quotient !== eq[i]) begin bad++; $display("FAIL b2b%0d_quot: got %h want %h", i, quotient, eq[i]); end
            total++; if (remainder !== er[i]) begin bad++; $display("FAIL b2b%0d_rem: got %h want %h", i, remainder, er[i]); end
        end
    endtask

    task automatic test_overflow();
        int lat, bh;
        run_div(4'h8, 4'hF, lat, bh);  // -8 / -1
        total++; if (lat !== 5) begin bad++; $display("FAIL ovf_latency: got %0d want 5", lat); end
        total++; if (quotient !== 4'h8) begin bad++; $display("FAIL ovf_quot: got %h want 8", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL ovf_rem: got %h want 0", remainder); end
`ifdef DIV_OVERFLOW_FLAG_EN
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`endif
    endtask

    task automatic test_div_by_zero();
        int lat, bh;
        int n;
        run_div(4'd5, 4'd0, lat, bh);
        total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        total++; if (quotient !== 4'hF) begin bad++; $display("FAIL dbz_quot: got %h want f", quotient); end
        total++; if (remainder !== 4'h5) begin bad++; $display("FAIL dbz_rem: got %h want 5", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
`ifdef DIV_OVERFLOW_FLAG_EN
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL dbz_ovf_clear: got %b want 0", overflow); end
`endif
        @(negedge clk);
        dividend = 4'd4; divisor = 4'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_cleared: got %b want 0", div_by_zero); end
        total++; if (quotient !== 4'h0) begin bad++; $display("FAIL dbz_quot_cleared: got %h want 0", quotient); end
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (n !== 5) begin bad++; $display("FAIL dbz_next_latency: got %0d want 5", n); end
        total++; if (quotient !== 4'd2) begin bad++; $display("FAIL dbz_next_quot: got %h want 2", quotient); end
    endtask

    task automatic test_start_while_busy();
        int ndone, lat;
        @(negedge clk);
        dividend = 4'd6; divisor = 4'd3; start = 1'b1;
        @(posedge clk);      // edge N
        #1;
        start = 1'b0;
        @(posedge clk);      // edge N+1
        @(negedge clk);
        dividend = 4'd1; divisor = 4'd1; start = 1'b1;
        @(posedge clk);      // edge N+2
        #1;
        start = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int k = 3; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL busy_start_dones: got %0d want 1", ndone); end
        total++; if (lat !== 5) begin bad++; $display("FAIL busy_start_latency: got %0d want 5", lat); end
        total++; if (quotient !== 4'd2) begin bad++; $display("FAIL busy_start_quot: got %h want 2", quotient); end
        total++; if (remainder !== 4'd0) begin bad++; $display("FAIL busy_start_rem: got %h want 0", remainder); end
    endtask

    task automatic test_reset_abort();
        int ndone, lat, bh;
        @(negedge clk);
        dividend = 4'd7; divisor = 4'd2; start = 1'b1;
        @(posedge clk);      // edge N
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (quotient !== 4'h0) begin bad++; $display("FAIL abort_quot: got %h want 0", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL abort_rem: got %h want 0", remainder); end
        ndone = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", ndone); end
        run_div(4'd6, 4'hE, lat, bh);  // 6 / -2
        total++; if (lat !== 5) begin bad++; $display("FAIL abort_next_latency: got %0d want 5", lat); end
        total++; if (quotient !== 4'hD) begin bad++; $display("FAIL abort_next_quot: got %h want d", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL abort_next_rem: got %h want 0", remainder); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
